buzzer_melody_seq: RTL and testbench

//  Note sequencer directly upstream of the buzzer square-wave generator.

---
 rtl/buzzer_melody_seq.sv | 143 ++++++++++++++
 tb/tb_buzzer_melody_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_melody_seq.sv
// Note sequencer feeding the buzzer square-wave generator: plays a writable
// table of {half-period, duration} entries, each followed by a fixed silent gap.
module buzzer_melody_seq #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int NOTES     = 16,
    parameter int HALF_W    = 24,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 20,
    parameter int LOOP      = 0,
    localparam int AW       = $clog2(NOTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [AW:0]       seq_len,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [HALF_W-1:0] wr_half,
    input  logic [DUR_W-1:0]  wr_dur,
    output logic [HALF_W-1:0] half_period,
    output logic              tone_en,
    output logic              busy,
    output logic [AW-1:0]     note_idx,
    output logic              done
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV + 1);
    localparam int GW       = $clog2(GAP_TICKS + 1);
    localparam int TW       = (DUR_W > GW) ? DUR_W : GW;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t            state, state_d;
    logic [HALF_W-1:0] tbl_half [NOTES];
    logic [DUR_W-1:0]  tbl_dur  [NOTES];
    logic [HALF_W-1:0] cur_half;
    logic [DUR_W-1:0]  cur_dur;
    logic [AW-1:0]     idx, idx_d;
    logic [PW-1:0]     pre, pre_d;
    logic [TW-1:0]     ticks, ticks_d, dur_last;
    logic [AW:0]       len_eff;
    logic              tick_end, last_note, load_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_half[wr_addr] <= wr_half;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    // The playing note works from its own copy, so table rewrites only take effect on the next LOAD
    always_ff @(posedge clk) begin
        if (load_en) begin
            cur_half <= tbl_half[idx];
            cur_dur  <= tbl_dur[idx];
        end
    end

    assign len_eff   = (seq_len > (AW+1)'(NOTES)) ? (AW+1)'(NOTES) : seq_len;
    assign last_note = ({1'b0, idx} + (AW+1)'(1)) >= len_eff;
    assign tick_end  = (pre == PW'(TICK_DIV - 1));
    assign dur_last  = (cur_dur == '0) ? '0 : TW'(cur_dur) - TW'(1);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        pre_d   = pre;
        ticks_d = ticks;
        load_en = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && seq_len != '0) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                pre_d   = '0;
                ticks_d = '0;
                state_d = PLAY;
            end
            PLAY, GAP: begin
                pre_d = tick_end ? '0 : pre + PW'(1);
                if (tick_end) begin
                    if ((state == PLAY && ticks == dur_last) ||
                        (state == GAP && ticks == TW'(GAP_TICKS - 1))) begin
                        ticks_d = '0;
                        if (state == PLAY && GAP_TICKS != 0) begin
                            state_d = GAP;
                        end else if (!last_note) begin
                            idx_d   = idx + AW'(1);
                            state_d = LOAD;
                        end else if (LOOP != 0) begin
                            idx_d   = '0;
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        ticks_d = ticks + TW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop && state != IDLE) begin
            state_d = IDLE;
        end
    end

    // Tone outputs trail the PLAY state by one clock; stop and end-of-sequence silence them at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            pre         <= '0;
            ticks       <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            pre     <= pre_d;
            ticks   <= ticks_d;
            if (state == PLAY) begin
                half_period <= cur_half;
            end
            tone_en <= (state == PLAY) && (state_d != IDLE) && (state_d != DONE) &&
                       (cur_half != '0);
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    assign note_idx = idx;

endmodule

// File: tb/tb_buzzer_melody_seq.sv
// Directed bench for buzzer_melody_seq: TICK_DIV=10, GAP_TICKS=1, one stop-at-end
// instance and one looping instance sharing the table write port.
module tb_buzzer_melody_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic [4:0]  seq_len = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [23:0] wr_half = '0;
    logic [11:0] wr_dur = '0;
    logic [23:0] half_period, half2;
    logic        tone_en, busy, done, tone2, busy2, done2;
    logic [3:0]  note_idx, idx2;

    int total = 0;
    int bad = 0;

    logic        tone_l [0:399];
    logic        done_l [0:399];
    logic        busy_l [0:399];
    logic [23:0] half_l [0:399];
    logic [3:0]  idx_l  [0:399];

    buzzer_melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .NOTES(16), .HALF_W(24), .DUR_W(12),
                        .GAP_TICKS(1), .LOOP(0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .seq_len(seq_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half), .wr_dur(wr_dur),
        .half_period(half_period), .tone_en(tone_en), .busy(busy),
        .note_idx(note_idx), .done(done));

    buzzer_melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .NOTES(16), .HALF_W(24), .DUR_W(12),
                        .GAP_TICKS(1), .LOOP(1)) dut_loop (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .seq_len(seq_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half), .wr_dur(wr_dur),
        .half_period(half2), .tone_en(tone2), .busy(busy2),
        .note_idx(idx2), .done(done2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int h, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_half = 24'(h); wr_dur = 12'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge right after the start-sampling edge (cycle m=0)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic log(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            @(negedge clk);
            tone_l[i] = tone_en; done_l[i] = done; busy_l[i] = busy;
            half_l[i] = half_period; idx_l[i] = note_idx;
        end
    endtask

    function automatic int ones(input logic q [0:399], input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (q[i]) n++;
        return n;
    endfunction

    function automatic int rises(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (tone_l[i] && !tone_l[i-1]) n++;
        return n;
    endfunction

    initial begin
        int dcnt;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tone", tone_en, 0); chk("rst_busy", busy, 0); chk("rst_half", half_period, 0);
        chk("rst_idx", note_idx, 0); chk("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: three-entry melody with a rest in the middle
        wr(0, 'hFFF, 2); wr(1, 0, 1); wr(2, 'h7FF, 3);
        seq_len = 5'd3;
        pulse_start();
        log(1, 110);
        chk("t1_busy_m1", busy_l[1], 1);
        chk("t1_tone_m1", tone_l[1], 0);
        chk("t1_note0_len", ones(tone_l, 1, 21), 20);
        chk("t1_tone_m22", tone_l[22], 0);
        chk("t1_quiet", ones(tone_l, 22, 53), 0);
        chk("t1_note2_len", ones(tone_l, 54, 83), 30);
        chk("t1_tone_m84", tone_l[84], 0);
        chk("t1_half0", half_l[2], 'hFFF);
        chk("t1_half_rest", half_l[40], 0);
        chk("t1_half2", half_l[60], 'h7FF);
        chk("t1_idx30", idx_l[30], 0);
        chk("t1_idx31", idx_l[31], 1);
        chk("t1_idx60", idx_l[60], 2);
        chk("t1_done93", done_l[93], 1);
        chk("t1_done_cnt", ones(done_l, 1, 110), 1);
        chk("t1_busy93", busy_l[93], 1);
        chk("t1_busy94", busy_l[94], 0);

        // 2: asynchronous reset mid-note
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t2_pre_tone", tone_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("t2_rst_tone", tone_en, 0); chk("t2_rst_busy", busy, 0);
        chk("t2_rst_half", half_period, 0); chk("t2_rst_idx", note_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_idle_busy", busy, 0); chk("t2_idle_tone", tone_en, 0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t2_table_kept", half_period, 'hFFF);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        @(negedge clk);

        // 3: stop during the 2nd note, then start+stop together
        wr(1, 'h123, 2);
        pulse_start();
        log(1, 40);
        chk("t3_tone40", tone_l[40], 1); chk("t3_idx40", idx_l[40], 1);
        chk("t3_half40", half_l[40], 'h123);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        chk("t3_stop_busy", busy, 0); chk("t3_stop_tone", tone_en, 0);
        log(1, 100);
        chk("t3_no_done", ones(done_l, 1, 100), 0);
        chk("t3_stay_idle", ones(busy_l, 1, 100), 0);
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("t3_ss_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t3_ss_busy3", busy, 0);

        // 4: zero duration, zero length, oversized length
        wr(0, 'h55, 0);
        seq_len = 5'd1;
        pulse_start();
        log(1, 30);
        chk("t4_dur0_len", ones(tone_l, 1, 30), 10);
        chk("t4_dur0_done", done_l[21], 1);
        seq_len = 5'd0;
        pulse_start();
        chk("t4_len0_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("t4_len0_busy5", busy, 0);
        for (int i = 0; i < 16; i++) wr(i, i + 1, 1);
        seq_len = 5'd31;
        pulse_start();
        log(1, 345);
        chk("t4_clamp_tone", ones(tone_l, 1, 345), 160);
        chk("t4_clamp_notes", rises(2, 345), 16);
        chk("t4_clamp_half0", half_l[2], 1);
        chk("t4_clamp_half15", half_l[317], 16);
        chk("t4_clamp_idx15", idx_l[330], 15);
        chk("t4_clamp_done", done_l[336], 1);
        chk("t4_clamp_busy", busy_l[337], 0);

        // 5: looping instance, two entries
        wr(0, 'h10, 1); wr(1, 'h20, 1);
        seq_len = 5'd2;
        start2 = 1'b1; @(negedge clk); start2 = 1'b0;
        dcnt = 0;
        for (int m = 1; m <= 120; m++) begin
            @(negedge clk);
            if (done2) dcnt++;
            if (m == 10) chk("t5_idx10", idx2, 0);
            if (m == 30) chk("t5_idx30", idx2, 1);
            if (m == 50) chk("t5_idx50", idx2, 0);
            if (m == 70) chk("t5_idx70", idx2, 1);
        end
        chk("t5_no_done", dcnt, 0);
        chk("t5_busy", busy2, 1);
        stop2 = 1'b1; @(negedge clk); stop2 = 1'b0;
        chk("t5_stop_busy", busy2, 0); chk("t5_stop_tone", tone2, 0);

        // 6: start while busy, rewrite of the playing entry
        wr(0, 'hAB, 3);
        seq_len = 5'd1;
        pulse_start();
        log(1, 15);
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_half = 24'hCD; wr_dur = 12'd3;
        log(16, 16);
        start = 1'b0; wr_en = 1'b0;
        log(17, 60);
        chk("t6_len", ones(tone_l, 1, 60), 30);
        chk("t6_half20", half_l[20], 'hAB);
        chk("t6_half31", half_l[31], 'hAB);
        chk("t6_done41", done_l[41], 1);
        chk("t6_done_cnt", ones(done_l, 1, 60), 1);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t6_new_half", half_period, 'hCD);
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
